// File: rtl/pwm_duty_ramper.sv
// pwm_duty_ramper: four-channel duty-cycle ramper for PWM generators.
// Commands set a per-channel target and step. Each tick starts a four-cycle
// scan that moves every channel one step toward its target.
// Optional feature macro: PWM_DUTY_RAMPER_OVERRUN_EN. It adds a sticky overrun
// flag for ticks that are lost while a scan is already busy.
module pwm_duty_ramper #(
  parameter int          STEP_W   = 4,
  parameter logic [7:0]  DUTY_RST = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_chan,
  input  logic [7:0]        cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              tick,
  output logic [7:0]        duty_1,
  output logic [7:0]        duty_2,
  output logic [7:0]        duty_3,
  output logic [7:0]        duty_4,
  output logic [3:0]        busy,
  output logic [3:0]        ramp_done
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
  ,
  output logic              overrun,
  input  logic              overrun_clr
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic                     pend_q, pend_d;
  logic                     accept;
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
  logic                     drop;
  logic                     overrun_q;
`endif

  logic [3:0][7:0]          duty_q;
  logic [3:0][7:0]          tgt_q;
  logic [3:0][STEP_W-1:0]   step_q;
  logic [7:0]               next_duty;

  // Upward move, saturating at the target; 9 bits so 8'hFF + step cannot wrap.
  function automatic logic [7:0] sat_up(input logic [7:0] cur, input logic [7:0] tgt,
                                        input logic [STEP_W-1:0] stp);
    logic [8:0] sum;
    sum = {1'b0, cur} + {{(9-STEP_W){1'b0}}, stp};
    sat_up = (sum >= {1'b0, tgt}) ? tgt : sum[7:0];
  endfunction

  // Downward move, saturating at the target; signed 9 bits so 0 - step stays negative.
  function automatic logic [7:0] sat_down(input logic [7:0] cur, input logic [7:0] tgt,
                                          input logic [STEP_W-1:0] stp);
    logic signed [8:0] diff;
    diff = $signed({1'b0, cur}) - $signed({{(9-STEP_W){1'b0}}, stp});
    sat_down = (diff <= $signed({1'b0, tgt})) ? tgt : diff[7:0];
  endfunction

  // FSM state, scan index and pending-tick flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic: accept commands in IDLE, walk the four channels in SCAN.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
    drop      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (tick || pend_q) begin
          state_d = SCAN;
          idx_d   = 2'd0;
          pend_d  = 1'b0;
        end
      end
      SCAN: begin
        // Only one tick is remembered; a second one during the scan is lost.
        if (tick) begin
          if (pend_q) begin
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
            drop = 1'b1;
`endif
          end else begin
            pend_d = 1'b1;
          end
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Candidate duty for the channel under scan; a zero step leaves it unchanged.
  always_comb begin
    next_duty = duty_q[idx_q];
    if (duty_q[idx_q] < tgt_q[idx_q])
      next_duty = sat_up(duty_q[idx_q], tgt_q[idx_q], step_q[idx_q]);
    else if (duty_q[idx_q] > tgt_q[idx_q])
      next_duty = sat_down(duty_q[idx_q], tgt_q[idx_q], step_q[idx_q]);
  end

  // Channel registers: command writes in IDLE, one channel update per SCAN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q    <= {4{DUTY_RST}};
      tgt_q     <= {4{DUTY_RST}};
      step_q    <= {4{STEP_W'(1)}};
      ramp_done <= 4'b0000;
    end else begin
      ramp_done <= 4'b0000;
      if (accept) begin
        tgt_q[cmd_chan]  <= cmd_target;
        step_q[cmd_chan] <= cmd_step;
        if (cmd_step == '0) duty_q[cmd_chan] <= cmd_target;
      end
      if (state_q == SCAN) begin
        duty_q[idx_q]    <= next_duty;
        ramp_done[idx_q] <= (duty_q[idx_q] != tgt_q[idx_q]) && (next_duty == tgt_q[idx_q]);
      end
    end
  end

`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
  // Sticky overrun flag; a new lost tick outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)              overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (overrun_clr) overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;
`endif

  assign duty_1 = duty_q[0];
  assign duty_2 = duty_q[1];
  assign duty_3 = duty_q[2];
  assign duty_4 = duty_q[3];

  // A channel is busy until its duty has reached the target.
  always_comb begin
    for (int k = 0; k < 4; k++) busy[k] = (duty_q[k] != tgt_q[k]);
  end

endmodule

// File: tb/tb_pwm_duty_ramper.sv
// Randomized and directed bench for pwm_duty_ramper against a behavioural model.
module tb_pwm_duty_ramper;

  localparam logic [7:0] DR = 8'h00;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, tick;
  logic [1:0] cmd_chan;
  logic [7:0] cmd_target;
  logic [3:0] cmd_step;
  logic [7:0] duty_1, duty_2, duty_3, duty_4;
  logic [3:0] busy, ramp_done;
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
  logic       overrun, overrun_clr;
`endif

  pwm_duty_ramper #(.STEP_W(4), .DUTY_RST(DR)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_target(cmd_target), .cmd_step(cmd_step),
    .tick(tick), .duty_1(duty_1), .duty_2(duty_2), .duty_3(duty_3),
    .duty_4(duty_4), .busy(busy), .ramp_done(ramp_done)
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
    , .overrun(overrun), .overrun_clr(overrun_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: channel values, scan position (-1 = idle, else channel being scanned).
  int m_duty[4], m_tgt[4], m_step[4];
  int m_scan, m_pend, m_ovr;
  logic [3:0] m_rd;
  int rdcnt[4];
  bit last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int move(input int cur, input int tgt, input int stp);
    if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
    if (cur > tgt) return (cur - stp < tgt) ? tgt : cur - stp;
    return cur;
  endfunction

  // One clock: drive inputs, advance the model, clock the DUT, compare.
  task automatic cyc(input bit r, input bit v, input int ch, input int t, input int s,
                     input bit tk, input bit clr);
    int i, nd;
    bit lost;
    rst = r; cmd_valid = v; cmd_chan = 2'(ch); cmd_target = 8'(t); cmd_step = 4'(s); tick = tk;
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
    overrun_clr = clr;
`endif
    last_acc = v && (m_scan < 0) && !r;
    m_rd = 4'b0000;
    lost = 1'b0;
    if (r) begin
      for (int k = 0; k < 4; k++) begin m_duty[k] = DR; m_tgt[k] = DR; m_step[k] = 1; end
      m_scan = -1; m_pend = 0; m_ovr = 0;
    end else begin
      if (m_scan < 0) begin
        if (v) begin
          m_tgt[ch] = t; m_step[ch] = s;
          if (s == 0) m_duty[ch] = t;
        end
        if (tk || m_pend != 0) begin m_scan = 0; m_pend = 0; end
      end else begin
        i = m_scan;
        nd = move(m_duty[i], m_tgt[i], m_step[i]);
        if (m_duty[i] != m_tgt[i] && nd == m_tgt[i]) m_rd[i] = 1'b1;
        m_duty[i] = nd;
        if (tk) begin
          if (m_pend != 0) lost = 1'b1;
          else m_pend = 1;
        end
        m_scan = (i == 3) ? -1 : i + 1;
      end
      if (lost) m_ovr = 1;
      else if (clr) m_ovr = 0;
    end
    @(posedge clk);
    #1;
    check("duty_1", 32'(duty_1), 32'(m_duty[0]));
    check("duty_2", 32'(duty_2), 32'(m_duty[1]));
    check("duty_3", 32'(duty_3), 32'(m_duty[2]));
    check("duty_4", 32'(duty_4), 32'(m_duty[3]));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_duty[k] != m_tgt[k]));
      if (ramp_done[k] === 1'b1) rdcnt[k]++;
    end
    check("ramp_done", 32'(ramp_done), 32'(m_rd));
    check("cmd_ready", 32'(cmd_ready), 32'(m_scan < 0));
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
    check("overrun", 32'(overrun), 32'(m_ovr));
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 4; k++) rdcnt[k] = 0;
  endtask

  logic [7:0] exp_ramp [4];
  int k_hold;

  initial begin
    exp_ramp[0] = 8'h04; exp_ramp[1] = 8'h08; exp_ramp[2] = 8'h0C; exp_ramp[3] = 8'h10;
    m_scan = -1; m_pend = 0; m_ovr = 0;
    clr_counts();

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_duty_1", 32'(duty_1), 32'(DR));
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // Ramp 0 -> 0x10 in steps of 4
    cyc(0, 1, 0, 8'h10, 4, 0, 0);
    for (int n = 0; n < 4; n++) begin
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(6);
      check("ramp_duty_1", 32'(duty_1), 32'(exp_ramp[n]));
    end
    check("ramp_done0_count", 32'(rdcnt[0]), 32'd1);

    // No wrap past 0xFF
    clr_counts();
    cyc(0, 1, 1, 8'hFE, 0, 0, 0);
    cyc(0, 1, 1, 8'hFF, 15, 1, 0);
    idle(6);
    check("nowrap_duty_2", 32'(duty_2), 32'hFF);
    check("nowrap_busy1", 32'(busy[1]), 32'd0);
    check("nowrap_done1", 32'(rdcnt[1]), 32'd1);

    // Immediate jump with step 0
    clr_counts();
    cyc(0, 1, 2, 8'h80, 0, 0, 0);
    check("jump_duty_3", 32'(duty_3), 32'h80);
    check("jump_busy2", 32'(busy[2]), 32'd0);
    idle(2);
    check("jump_done2", 32'(rdcnt[2]), 32'd0);

    // Two ticks inside one scan -> exactly one extra scan
    cyc(0, 1, 3, 8'hC0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(12);
    check("extra_scan_duty_4", 32'(duty_4), 32'd2);
`ifdef PWM_DUTY_RAMPER_OVERRUN_EN
    check("overrun_set", 32'(overrun), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("overrun_clr", 32'(overrun), 32'd0);
`endif

    // Command held through a scan, then a coincident command and tick
    cyc(0, 0, 0, 0, 0, 1, 0);
    k_hold = 0;
    do begin
      cyc(0, 1, 0, 8'h00, 2, 0, 0);
      k_hold++;
    end while (!last_acc && k_hold < 10);
    check("hold_cycles", 32'(k_hold), 32'd5);
    cyc(0, 1, 0, 8'h40, 8, 1, 0);
    idle(6);
    check("coincident_duty_1", 32'(duty_1), 32'h18);

    // Reset in the middle of a scan
    clr_counts();
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_duty_4", 32'(duty_4), 32'(DR));
    idle(6);
    check("midrst_done", 32'(rdcnt[0] + rdcnt[1] + rdcnt[2] + rdcnt[3]), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int st;
      st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 255)),
          st,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramper.md
PWM_DUTY_RAMPER -- requirements
Module: pwm_duty_ramper

Interface
REQ-001 The block SHALL have parameter STEP_W, default 4, giving the width of the per-channel ramp step.
REQ-002 The block SHALL have parameter DUTY_RST, default 8'h00, giving the reset value of every duty output and target.
REQ-003 Port clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  in  1  reset, synchronous and active-high.
REQ-005 Port cmd_valid  in  1  command request.
REQ-006 Port cmd_ready  out  1  command accept.
REQ-007 Port cmd_chan  in  2  target generator, 0..3 = generators 1..4.
REQ-008 Port cmd_target  in  8  target duty cycle.
REQ-009 Port cmd_step  in  STEP_W  per-update step size; 0 = jump immediately.
REQ-010 Port tick  in  1  one-cycle update strobe, nominally once per PWM period.
REQ-011 Port duty_1..duty_4  out  8 each  duty-cycle values driving the PWM generator duty registers.
REQ-012 Port busy  out  4  bit N high while duty_(N+1) != target N.
REQ-013 Port ramp_done  out  4  bit N is a one-cycle pulse when channel N reaches its target by ramping.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SCAN, with a 2-bit scan index.
REQ-015 cmd_ready SHALL be 1 exactly when the state is IDLE; a command is accepted on a clk edge with cmd_valid & cmd_ready.
REQ-016 On accept, the block SHALL store target[cmd_chan] and step[cmd_chan]; if cmd_step == 0, duty[cmd_chan] SHALL equal cmd_target on the same edge, with no ramp_done pulse.
REQ-017 A tick in IDLE, or a pending tick in IDLE, SHALL move the FSM to SCAN with index 0 on the next edge and clear the pending flag.
REQ-018 In SCAN, on each cycle with index i, the block SHALL update channel i; the index SHALL then increment, and after i=3 the FSM SHALL return to IDLE (4 cycles per scan).
REQ-019 Channel update rule when duty < target: duty = min(duty + step, target), computed in 9 bits, with no wrap past 8'hFF.
REQ-020 Channel update rule when duty > target: duty = max(duty - step, target), computed in 9 bits signed, with no wrap below 0.
REQ-021 Channel update rule when duty == target: duty unchanged, no pulse.
REQ-022 ramp_done[i] SHALL pulse on the cycle after the SCAN update that makes duty equal to target.
REQ-023 A tick received in SCAN SHALL set a 1-bit pending flag; further ticks while the flag is already set are dropped.
REQ-024 When a command and a tick coincide in IDLE, the command SHALL be accepted first, and the following scan SHALL use the new target and step.
REQ-025 A new command to a channel with a ramp in progress SHALL retarget it from its current duty; duty SHALL not be reset.
REQ-026 A channel with step 0 and an unequal target is impossible per REQ-016; a scan of such a channel SHALL leave duty unchanged.

Reset
REQ-027 While rst is high at a clk edge, the block SHALL set: state=IDLE, index=0, pending=0, all duty and target = DUTY_RST, all step = 1, busy=0, ramp_done=0, overrun=0.
REQ-028 Reset mid-scan SHALL abort the scan with no further duty updates; cmd_ready SHALL be 1 on the cycle after rst deasserts.

Configuration
REQ-029 Macro PWM_DUTY_RAMPER_OVERRUN_EN, when defined, SHALL add port overrun (out 1) and port overrun_clr (in 1).
REQ-030 With the macro defined, a tick that is dropped per REQ-023 SHALL set overrun sticky; overrun_clr SHALL clear it, and a set in the same cycle wins.
REQ-031 Without the macro, the overrun ports SHALL be absent and dropped ticks SHALL be silent; all other behaviour SHALL be identical.

Verification
REQ-032 After reset, cmd chan=0 target=8'h10 step=4, then 4 ticks spaced >=6 cycles -> duty_1 = 04, 08, 0C, 10; ramp_done[0] pulses once, on the 4th scan.
REQ-033 duty_2=8'hFE, cmd chan=1 target=8'hFF step=15, then tick -> duty_2 = FF (no wrap); busy[1] falls; ramp_done[1] pulses.
REQ-034 cmd chan=2 target=8'h80 step=0 -> duty_3 = 80 on the accept edge; busy[2]=0; no ramp_done pulse.
REQ-035 Ticks on SCAN cycles 1 and 2 -> exactly one extra scan follows; with PWM_DUTY_RAMPER_OVERRUN_EN, overrun=1 until overrun_clr.
REQ-036 cmd_valid held during SCAN -> cmd_ready=0 for 4 cycles and the command is accepted on the first IDLE cycle; coincident tick and cmd in IDLE -> scan uses the new target.
REQ-037 Assert rst on SCAN index 2 -> all duties = DUTY_RST, state IDLE, and no ramp_done pulse.
